apa102_frame_tx: RTL
====================

// Module: apa102_frame_tx
// PURPOSE
//  Streaming APA102 strand serializer with a valid/ready pixel interface; replaces the free-running shift-register SPI.
//  On a start pulse it emits one complete strand frame: 32-bit start frame, NUM_LEDS LED frames, 32-bit end frame.
//  Sits downstream of the colour/pattern generators (solid lantern colour, rain pattern) and drives one strand's sck/mosi pins.
//  Frame timing is exact and reported by busy/done, so upstream stages can update pixels between frames without tearing.
// PARAMETERS
//  NUM_LEDS  14  LEDs on the strand; LED frames per transfer (>=1)
//  HALF_DIV  64  clk cycles per sck half-period (>=1); 64 matches the existing counter[6] sck rate
// PORTS
//  clk             in   1  system clock
//  reset           in   1  asynchronous, active-high reset
//  start           in   1  frame request; sampled only in IDLE
//  busy            out  1  high while a frame is in progress
//  done            out  1  one-cycle pulse when a frame completes
//  pix_valid       in   1  upstream pixel available
//  pix_ready       out  1  block accepts a pixel this cycle
//  pix_brightness  in   5  global brightness field for this LED
//  pix_blue        in   8  blue
//  pix_green       in   8  green
//  pix_red         in   8  red
//  sck             out  1  strand clock; idles low
//  mosi            out  1  strand data; MSB first; changes only while sck is low
// BEHAVIOUR
//  Reset (async): state=IDLE; sck=0, mosi=0, busy=0, done=0, pix_ready=0; all counters cleared. Applies mid-frame too; the partial frame is abandoned and no done pulse is produced.
//  States: IDLE -> SFRAME -> FETCH -> LFRAME -> (FETCH | EFRAME) -> IDLE.
//  IDLE: if start=1, the next cycle enters SFRAME with shift word 32'h00000000. start is ignored in every other state.
//  Bit cell: mosi = shift[31] for HALF_DIV cycles with sck=0, then HALF_DIV cycles with sck=1.
//    On the cycle sck falls, the word shifts left and the bit counter increments.
//    After bit 31's high phase:
//      SFRAME -> FETCH, LFRAME -> FETCH while fewer than NUM_LEDS LEDs have been sent, else LFRAME -> EFRAME, EFRAME -> IDLE.
//  FETCH: pix_ready=1 (decoded from state only; no dependence on pix_valid).
//    sck is held 0 and mosi holds its last value.
//    On pix_valid&pix_ready the word {3'b111, pix_brightness, pix_blue, pix_green, pix_red} is latched.
//    The next cycle is LFRAME and mosi shows its bit 31.
//    With pix_valid low, FETCH stalls indefinitely with sck low (legal for APA102).
//  EFRAME: shift word 32'hFFFFFFFF.
//  busy=1 in every state except IDLE. done=1 for exactly the first IDLE cycle after EFRAME completes.
//  Stall-free duration: busy high for exactly (NUM_LEDS+2)*32*2*HALF_DIV + NUM_LEDS cycles.
//  Widths: bit counter 5 bits, wraps 31->0 at word end. LED counter is $clog2(NUM_LEDS+1) bits. Divider is $clog2(HALF_DIV+1) bits and reloads at each sck edge.
//  Simultaneous start and done cycle: start in that IDLE cycle is honoured, so back-to-back frames are allowed.
//  Outputs are registered; no combinational path from inputs to sck, mosi or busy.
// TESTING
//  1. NUM_LEDS=1, HALF_DIV=2; start with pix_valid=1 and pixel (1F,00,FF,00).
//     Sample mosi on each sck rise: 96 bits = 00000000_FF00FF00_FFFFFFFF.
//     busy high 385 cycles; done is a single pulse.
//  2. Defaults (NUM_LEDS=14, HALF_DIV=64), pix_valid always 1: exactly 512 sck rising edges.
//     sck period is 128 clk. Exactly 14 pix handshakes; busy high 65550 cycles.
//  3. Stall: hold pix_valid=0 for 50 cycles at the second FETCH.
//     sck stays 0 and pix_ready stays 1 throughout; the captured bitstream is identical to the no-stall run.
//     busy is 50 cycles longer.
//  4. Pulse start repeatedly while busy: only one frame is produced (bit count unchanged).
//     Assert start during the done cycle: a second frame follows with no idle gap.
//  5. Assert reset at bit 10 of LED 0: sck, mosi, busy, pix_ready are 0 the same cycle; no done pulse.
//     A new start produces a complete, correct frame.
//  6. Ready/valid check: pix_ready is never high outside FETCH, and pixel inputs changed while pix_ready=0 never alter the emitted data.

Source files
------------

// File: rtl/apa102_frame_tx.sv
// APA102 strand serializer: start frame, NUM_LEDS pixel frames, end frame.
// Pixels arrive over valid/ready; sck/mosi are registered.
module apa102_frame_tx #(
  parameter int NUM_LEDS = 14,
  parameter int HALF_DIV = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic [4:0] pix_brightness,
  input  logic [7:0] pix_blue,
  input  logic [7:0] pix_green,
  input  logic [7:0] pix_red,
  output logic       sck,
  output logic       mosi
);

  localparam int DW = $clog2(HALF_DIV + 1);
  localparam int LW = $clog2(NUM_LEDS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF_DIV - 1);
  localparam logic [LW-1:0] LED_LAST = LW'(NUM_LEDS);

  typedef enum logic [2:0] {
    IDLE,
    SFRAME,
    FETCH,
    LFRAME,
    EFRAME
  } state_t;

  state_t        state, state_n;
  logic [31:0]   shift, shift_n;
  logic [4:0]    bitcnt, bit_n;
  logic [LW-1:0] ledcnt, led_n;
  logic [DW-1:0] div, div_n;
  logic          sck_n;
  logic          done_n;
  logic [31:0]   pix_word;

  assign pix_word  = {3'b111, pix_brightness,
                      pix_blue, pix_green, pix_red};
  assign busy      = (state != IDLE);
  assign pix_ready = (state == FETCH);
  // The last bit is never shifted out, so mosi holds through FETCH.
  assign mosi      = shift[31];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      shift  <= '0;
      bitcnt <= '0;
      ledcnt <= '0;
      div    <= '0;
      sck    <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      shift  <= shift_n;
      bitcnt <= bit_n;
      ledcnt <= led_n;
      div    <= div_n;
      sck    <= sck_n;
      done   <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_n   = bitcnt;
    led_n   = ledcnt;
    div_n   = div;
    sck_n   = sck;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = SFRAME;
          shift_n = '0;
          bit_n   = '0;
          led_n   = '0;
          div_n   = '0;
          sck_n   = 1'b0;
        end
      end
      FETCH: begin
        if (pix_valid) begin
          state_n = LFRAME;
          shift_n = pix_word;
          led_n   = ledcnt + LW'(1);
          div_n   = '0;
        end
      end
      SFRAME, LFRAME, EFRAME: begin
        if (div != DIV_LAST) begin
          div_n = div + DW'(1);
        end else begin
          div_n = '0;
          sck_n = ~sck;
          if (sck) begin
            bit_n = bitcnt + 5'd1;
            if (bitcnt != 5'd31) begin
              shift_n = {shift[30:0], 1'b0};
            end else if (state == SFRAME) begin
              state_n = FETCH;
            end else if (state == LFRAME &&
                         ledcnt != LED_LAST) begin
              state_n = FETCH;
            end else if (state == LFRAME) begin
              state_n = EFRAME;
              shift_n = '1;
            end else begin
              state_n = IDLE;
              shift_n = '0;
              done_n  = 1'b1;
            end
          end
        end
      end
    endcase
  end

endmodule
